// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: EX-stage multiply/divide sequencer.
// Handles MULT/MULTU with iterative radix-2 shift-add and DIV/DIVU with
// restoring division. Operand magnitudes are latched at accept, and the
// sign is fixed up on entry to DONE. The 64-bit {HI,LO} result is held
// until the next completion.
// Optional build macro: MULDIV_FAST_MUL_EN selects a single registered
// multiply, so MUL takes one cycle instead of WIDTH cycles.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 exceptionD,
  input  logic                 flush,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   hilo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  logic [1:0]           state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;      // signed op
  logic                 sa_q, sa_d;        // sign of a (signed ops only)
  logic                 sb_q, sb_d;        // sign of b (signed ops only)
  logic [WIDTH-1:0]     opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   work_q, work_d;    // {acc,multiplier} or {rem,quotient}
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;

  logic                 accept;
  logic                 is_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;

  logic [WIDTH:0]       div_rem;
  logic [WIDTH:0]       div_diff;
  logic                 div_ok;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     fix_quo, fix_rem;

`ifdef MULDIV_FAST_MUL_EN
  logic                 ext_a, ext_b;
  logic [2*WIDTH-1:0]   fast_prod;
`else
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   fix_prod;
`endif

  // Operand conditioning, accept decision and one datapath iteration.
  always_comb begin
    accept    = (state_q == S_IDLE) & start & ~exceptionD & ~flush;
    is_signed = ~op[0];
    mag_a     = (is_signed & a[WIDTH-1]) ? -a : a;
    mag_b     = (is_signed & b[WIDTH-1]) ? -b : b;

    // Restoring divide step: shift in the next dividend bit, trial subtract.
    div_rem  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    div_ok   = ~div_diff[WIDTH];
    div_next = {(div_ok ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                work_q[WIDTH-2:0], div_ok};
    fix_quo  = (sgn_q & (sa_q ^ sb_q)) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    fix_rem  = (sgn_q & sa_q) ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    ext_a     = is_signed & a[WIDTH-1];
    ext_b     = is_signed & b[WIDTH-1];
    // Sign-extended operands, truncated to 2*WIDTH, give the signed product.
    fast_prod = {{WIDTH{ext_a}}, a} * {{WIDTH{ext_b}}, b};
`else
    // Shift-add step: add multiplicand on LSB of multiplier, shift right.
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (work_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    fix_prod = (sgn_q & (sa_q ^ sb_q)) ? -mul_next : mul_next;
`endif
  end

  // Next-state logic. Flush wins over every non-reset transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    hilo_d  = hilo_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sgn_d = is_signed;
            sa_d  = is_signed & a[WIDTH-1];
            sb_d  = is_signed & b[WIDTH-1];
            cnt_d = '0;
            if (op[1]) begin
              if (b == '0) begin
                state_d = S_DONE;
                hilo_d  = {a, {WIDTH{1'b1}}};
              end else begin
                state_d = S_DIV;
                work_d  = {{WIDTH{1'b0}}, mag_a};
                opnd_d  = mag_b;
              end
            end else begin
              state_d = S_MUL;
`ifdef MULDIV_FAST_MUL_EN
              work_d  = fast_prod;
`else
              work_d  = {{WIDTH{1'b0}}, mag_b};
              opnd_d  = mag_a;
`endif
            end
          end
        end
        S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = S_DONE;
          hilo_d  = work_q;
`else
          work_d = mul_next;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            hilo_d  = fix_prod;
          end
`endif
        end
        S_DIV: begin
          work_d = div_next;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
            hilo_d  = {fix_rem, fix_quo};
          end
        end
        default: begin
          // DONE: the resident instruction's start is ignored here.
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      work_q  <= '0;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      hilo_q  <= hilo_d;
    end
  end

  // Outputs: stall covers the accept cycle and all iterating cycles.
  always_comb begin
    stall = ~flush & (accept | (state_q == S_MUL) | (state_q == S_DIV));
    done  = ~flush & (state_q == S_DONE);
    hilo  = hilo_q;
  end

endmodule
